// File: rtl/net_perf_pkg.sv
// Shared types and register indices for the windowed network performance monitor.
package net_perf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } perf_state_t;

    localparam int REG_STATUS  = 0;
    localparam int REG_WIN     = 1;
    localparam int REG_CYC     = 2;
    localparam int REG_CH_BASE = 3;

    localparam int EVT_W = 32;

endpackage

// File: rtl/net_perf_chan_cnt.sv
// One monitored stream: saturating live event/byte counters with a snapshot
// register that captures live plus the current cycle's increment.
module net_perf_chan_cnt
    import net_perf_pkg::*;
#(
    parameter int LEN_W = 16,
    parameter int CNT_W = 64
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             clr,
    input  logic             cnt_en,
    input  logic             fire,
    input  logic             ok,
    input  logic [LEN_W-1:0] len,
    input  logic             snap,
    output logic [EVT_W-1:0] snap_evt,
    output logic [CNT_W-1:0] snap_byte
);

    logic [EVT_W-1:0] evt_live;
    logic [EVT_W-1:0] evt_nxt;
    logic [EVT_W:0]   evt_sum;
    logic [CNT_W-1:0] byte_live;
    logic [CNT_W-1:0] byte_nxt;
    logic [CNT_W:0]   byte_sum;
    logic [CNT_W:0]   byte_inc;

    // One spare carry bit per adder: carry out means clamp to all-ones.
    always_comb begin
        evt_sum  = {1'b0, evt_live} + {{EVT_W{1'b0}}, cnt_en & fire};
        evt_nxt  = evt_sum[EVT_W] ? '1 : evt_sum[EVT_W-1:0];
        byte_inc = (cnt_en && fire && ok) ? {{(CNT_W + 1 - LEN_W){1'b0}}, len} : '0;
        byte_sum = {1'b0, byte_live} + byte_inc;
        byte_nxt = byte_sum[CNT_W] ? '1 : byte_sum[CNT_W-1:0];
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            evt_live  <= '0;
            byte_live <= '0;
            snap_evt  <= '0;
            snap_byte <= '0;
        end else if (clr) begin
            evt_live  <= '0;
            byte_live <= '0;
            snap_evt  <= '0;
            snap_byte <= '0;
        end else if (snap) begin
            snap_evt  <= evt_nxt;
            snap_byte <= byte_nxt;
            evt_live  <= '0;
            byte_live <= '0;
        end else begin
            evt_live  <= evt_nxt;
            byte_live <= byte_nxt;
        end
    end

endmodule

// File: rtl/net_perf_monitor.sv
// Windowed handshake/byte monitor over NUM_CH snooped streams with a
// registered read port; purely observational, drives nothing on the datapath.
//
//   state | meaning
//   IDLE  | waiting for a start trigger
//   RUN   | window open, counting; cyc tracks position in the window
//   DONE  | one-shot window finished, counters frozen until cfg_clear
module net_perf_monitor
    import net_perf_pkg::*;
#(
    parameter int          NUM_CH     = 4,
    parameter int          LEN_W      = 16,
    parameter int          CNT_W      = 64,
    parameter int unsigned DEF_WINDOW = 750000000
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      trig_valid,
    input  logic                      trig_ready,
    input  logic [NUM_CH-1:0]         ev_valid,
    input  logic [NUM_CH-1:0]         ev_ready,
    input  logic [NUM_CH-1:0]         ev_ok,
    input  logic [NUM_CH*LEN_W-1:0]   ev_len,
    input  logic [31:0]               cfg_window,
    input  logic                      cfg_continuous,
    input  logic                      cfg_clear,
    input  logic                      rd_en,
    input  logic [7:0]                rd_addr,
    output logic                      rd_valid,
    output logic [63:0]               rd_data,
    output logic                      win_done,
    output logic                      busy
);

    perf_state_t      state;
    logic [31:0]      win_len;
    logic [31:0]      cyc;
    logic [15:0]      seq;
    logic [31:0]      new_len;
    logic [31:0]      cyc_eff;
    logic [31:0]      len_eff;
    logic             trigger;
    logic             start;
    logic             cnt_en;
    logic             terminal;
    logic [NUM_CH-1:0] fire;
    logic [EVT_W-1:0] snap_evt  [NUM_CH];
    logic [CNT_W-1:0] snap_byte [NUM_CH];
    logic [63:0]      rd_mux;

    assign trigger = trig_valid & trig_ready;
    assign fire    = ev_valid & ev_ready;
    assign busy    = (state == RUN);
    assign start   = (state == IDLE) && trigger && !cfg_clear;
    assign cnt_en  = start || (state == RUN);
    assign new_len = (cfg_window == 32'd0) ? 32'(DEF_WINDOW) : cfg_window;

    // The trigger cycle is cyc 0 of the new window, so a 1-cycle window
    // terminates on the trigger cycle itself.
    assign cyc_eff  = start ? 32'd0 : cyc;
    assign len_eff  = start ? new_len : win_len;
    assign terminal = cnt_en && (cyc_eff == len_eff - 32'd1);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= IDLE;
            win_len  <= '0;
            cyc      <= '0;
            seq      <= '0;
            win_done <= 1'b0;
        end else if (cfg_clear) begin
            state    <= IDLE;
            win_len  <= '0;
            cyc      <= '0;
            seq      <= '0;
            win_done <= 1'b0;
        end else begin
            win_done <= terminal;
            if (start) begin
                win_len <= new_len;
            end
            if (cnt_en) begin
                if (terminal) begin
                    seq   <= seq + 16'd1;
                    cyc   <= '0;
                    state <= cfg_continuous ? RUN : DONE;
                end else begin
                    cyc   <= cyc_eff + 32'd1;
                    state <= RUN;
                end
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        net_perf_chan_cnt #(
            .LEN_W (LEN_W),
            .CNT_W (CNT_W)
        ) u_cnt (
            .aclk      (aclk),
            .aresetn   (aresetn),
            .clr       (cfg_clear),
            .cnt_en    (cnt_en),
            .fire      (fire[c]),
            .ok        (ev_ok[c]),
            .len       (ev_len[c*LEN_W +: LEN_W]),
            .snap      (terminal),
            .snap_evt  (snap_evt[c]),
            .snap_byte (snap_byte[c])
        );
    end

    always_comb begin
        rd_mux = '0;
        if (rd_addr == 8'(REG_STATUS)) begin
            rd_mux = {32'b0, seq, 12'b0, state, cfg_continuous, busy};
        end else if (rd_addr == 8'(REG_WIN)) begin
            rd_mux = {32'b0, win_len};
        end else if (rd_addr == 8'(REG_CYC)) begin
            rd_mux = {32'b0, cyc};
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd_addr == 8'(REG_CH_BASE + 2*c)) begin
                rd_mux = {32'b0, snap_evt[c]};
            end
            if (rd_addr == 8'(REG_CH_BASE + 2*c + 1)) begin
                rd_mux = 64'(snap_byte[c]);
            end
        end
    end

    // Sampling pre-edge values means a read on a snapshot edge sees the old window.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_net_perf_monitor.sv
// Self-checking bench for net_perf_monitor: read-port scoreboard, register
// tables and hand-written window/clear/saturation/reset sequences.
module tb_net_perf_monitor;

    localparam int NUM_CH = 4;
    localparam int LEN_W  = 16;

    logic                     aclk = 1'b0;
    logic                     aresetn = 1'b0;
    logic                     trig_valid, trig_ready;
    logic [NUM_CH-1:0]        ev_valid, ev_ready, ev_ok;
    logic [NUM_CH*LEN_W-1:0]  ev_len;
    logic [31:0]              cfg_window;
    logic                     cfg_continuous, cfg_clear;
    logic                     rd_en;
    logic [7:0]               rd_addr;
    logic                     rd_valid;
    logic [63:0]              rd_data;
    logic                     win_done, busy;

    logic                     s_trig_valid, s_trig_ready;
    logic [0:0]               s_ev_valid, s_ev_ready, s_ev_ok;
    logic [7:0]               s_ev_len;
    logic [31:0]              s_cfg_window;
    logic                     s_cfg_continuous, s_cfg_clear;
    logic                     s_rd_en;
    logic [7:0]               s_rd_addr;
    logic                     s_rd_valid;
    logic [63:0]              s_rd_data;
    logic                     s_win_done, s_busy;

    always #5 aclk = ~aclk;

    net_perf_monitor u_dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .trig_valid     (trig_valid),
        .trig_ready     (trig_ready),
        .ev_valid       (ev_valid),
        .ev_ready       (ev_ready),
        .ev_ok          (ev_ok),
        .ev_len         (ev_len),
        .cfg_window     (cfg_window),
        .cfg_continuous (cfg_continuous),
        .cfg_clear      (cfg_clear),
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .win_done       (win_done),
        .busy           (busy)
    );

    // Narrow counters and a short default window make saturation reachable.
    net_perf_monitor #(
        .NUM_CH     (1),
        .LEN_W      (8),
        .CNT_W      (8),
        .DEF_WINDOW (20)
    ) u_sat (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .trig_valid     (s_trig_valid),
        .trig_ready     (s_trig_ready),
        .ev_valid       (s_ev_valid),
        .ev_ready       (s_ev_ready),
        .ev_ok          (s_ev_ok),
        .ev_len         (s_ev_len),
        .cfg_window     (s_cfg_window),
        .cfg_continuous (s_cfg_continuous),
        .cfg_clear      (s_cfg_clear),
        .rd_en          (s_rd_en),
        .rd_addr        (s_rd_addr),
        .rd_valid       (s_rd_valid),
        .rd_data        (s_rd_data),
        .win_done       (s_win_done),
        .busy           (s_busy)
    );

    typedef struct packed {
        logic [7:0]  addr;
        logic [63:0] exp;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t sb [$];
    vec_t tab1 [13];
    vec_t tab3 [8];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic issue(input logic [7:0] a, input logic [63:0] e);
        rd_en   = 1'b1;
        rd_addr = a;
        sb.push_back('{a, e});
    endtask

    task automatic rd(input logic [7:0] a, input logic [63:0] e);
        issue(a, e);
        @(negedge aclk);
        rd_en = 1'b0;
        chk("rd_latency_pending", 64'(sb.size()), 64'd0);
    endtask

    task automatic srd(input string name, input logic [7:0] a, input logic [63:0] e);
        s_rd_en   = 1'b1;
        s_rd_addr = a;
        @(negedge aclk);
        s_rd_en = 1'b0;
        chk({name, "_valid"}, 64'(s_rd_valid), 64'd1);
        chk(name, s_rd_data, e);
    endtask

    task automatic set_ev(input int ch, input logic [15:0] len, input logic ok);
        ev_valid[ch] = 1'b1;
        ev_ready[ch] = 1'b1;
        ev_ok[ch]    = ok;
        ev_len[ch*LEN_W +: LEN_W] = len;
    endtask

    task automatic clr_ev();
        ev_valid = '0;
        ev_ready = '0;
        ev_ok    = '0;
        ev_len   = '0;
    endtask

    task automatic pulse_trig();
        trig_valid = 1'b1;
        trig_ready = 1'b1;
        @(negedge aclk);
        trig_valid = 1'b0;
        trig_ready = 1'b0;
    endtask

    task automatic pulse_clear();
        cfg_clear = 1'b1;
        @(negedge aclk);
        cfg_clear = 1'b0;
    endtask

    always @(posedge aclk) begin
        vec_t e;
        #1;
        if (rd_valid) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rd_unexpected: got rd_valid=1 with no read pending, required 0");
            end else begin
                e = sb.pop_front();
                chk($sformatf("rd_addr%0d", e.addr), rd_data, e.exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        int pulses;
        int pulse_err;

        trig_valid = 0; trig_ready = 0; clr_ev();
        cfg_window = 0; cfg_continuous = 0; cfg_clear = 0;
        rd_en = 0; rd_addr = 0;
        s_trig_valid = 0; s_trig_ready = 0; s_ev_valid = 0; s_ev_ready = 0; s_ev_ok = 0;
        s_ev_len = 0; s_cfg_window = 0; s_cfg_continuous = 0; s_cfg_clear = 0;
        s_rd_en = 0; s_rd_addr = 0;

        tab1 = '{'{8'd0, 64'h10008}, '{8'd1, 64'd100}, '{8'd2, 64'd0}, '{8'd3, 64'd10},
                 '{8'd4, 64'd640},   '{8'd5, 64'd0},   '{8'd6, 64'd0}, '{8'd7, 64'd0},
                 '{8'd8, 64'd0},     '{8'd9, 64'd0},   '{8'd10, 64'd0}, '{8'd11, 64'd0},
                 '{8'd200, 64'd0}};
        tab3 = '{'{8'd7, 64'd4}, '{8'd8, 64'd200}, '{8'd3, 64'd1}, '{8'd4, 64'd3},
                 '{8'd5, 64'd0}, '{8'd6, 64'd0},   '{8'd1, 64'd20}, '{8'd0, 64'h10008}};

        // reset state
        repeat (2) @(negedge aclk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_win_done", 64'(win_done), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_data", rd_data, 64'd0);
        aresetn = 1'b1;
        @(negedge aclk);
        rd(8'd0, 64'd0);
        rd(8'd1, 64'd0);
        rd(8'd2, 64'd0);

        // 1: one-shot window of 100, ch0 fires 10 times with len 64
        cfg_window = 100;
        set_ev(0, 16'd64, 1'b1);
        pulse_trig();
        first = -1; pulses = 0;
        for (int k = 1; k <= 110; k++) begin
            clr_ev();
            if (k < 10) set_ev(0, 16'd64, 1'b1);
            @(negedge aclk);
            if (win_done) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
        clr_ev();
        chk("t1_done_cycle", 64'(first), 64'd99);
        chk("t1_pulse_count", 64'(pulses), 64'd1);
        for (int i = 0; i < 13; i++) rd(tab1[i].addr, tab1[i].exp);
        pulse_trig();
        @(negedge aclk);
        chk("t1_trig_ignored_busy", 64'(busy), 64'd0);
        rd(8'd0, 64'h10008);

        // 2: continuous window of 8, ch1 fire on the terminal cycle
        pulse_clear();
        rd(8'd0, 64'd0);
        rd(8'd4, 64'd0);
        cfg_window = 8;
        cfg_continuous = 1;
        pulse_trig();
        pulse_err = 0;
        for (int k = 1; k <= 24; k++) begin
            clr_ev();
            rd_en = 1'b0;
            if (k == 3 || k == 7) set_ev(1, 16'd5, 1'b1);
            if (k == 8) set_ev(1, 16'd7, 1'b1);
            if (k == 20) set_ev(1, 16'd9, 1'b1);
            case (k)
                10: issue(8'd5, 64'd2);
                11: issue(8'd6, 64'd10);
                12: issue(8'd0, 64'h10007);
                13: issue(8'd2, 64'd5);
                15: issue(8'd5, 64'd2);
                16: issue(8'd5, 64'd1);
                17: issue(8'd6, 64'd7);
                default: ;
            endcase
            @(negedge aclk);
            if (win_done !== ((k % 8) == 7)) pulse_err++;
        end
        clr_ev();
        rd_en = 1'b0;
        chk("t2_win_done_pattern", 64'(pulse_err), 64'd0);
        rd(8'd0, 64'h30007);

        // 5: clear and trigger together on a terminal cycle (k = 31)
        repeat (5) @(negedge aclk);
        cfg_clear = 1; cfg_continuous = 0;
        trig_valid = 1; trig_ready = 1;
        @(negedge aclk);
        cfg_clear = 0; trig_valid = 0; trig_ready = 0;
        chk("t5_no_win_done", 64'(win_done), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        for (int a = 0; a <= 10; a++) rd(8'(a), 64'd0);
        cfg_window = 6;
        pulse_trig();
        chk("t5_restart_busy", 64'(busy), 64'd1);
        first = -1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge aclk);
            if (win_done && first < 0) first = k;
        end
        chk("t5_restart_done_cycle", 64'(first), 64'd5);
        rd(8'd0, 64'h10008);
        rd(8'd1, 64'd6);

        // 3: ev_ok filtering on ch2, plus an unready valid that must not count
        pulse_clear();
        cfg_window = 20;
        pulse_trig();
        first = -1;
        for (int k = 1; k <= 25; k++) begin
            clr_ev();
            if (k <= 4) set_ev(2, 16'd100, 1'(k % 2));
            if (k == 2) set_ev(0, 16'd3, 1'b1);
            if (k == 5) begin
                ev_valid[2] = 1'b1;
                ev_ok[2]    = 1'b1;
                ev_len[2*LEN_W +: LEN_W] = 16'd55;
            end
            @(negedge aclk);
            if (win_done && first < 0) first = k;
        end
        clr_ev();
        chk("t3_done_cycle", 64'(first), 64'd19);
        for (int i = 0; i < 8; i++) rd(tab3[i].addr, tab3[i].exp);

        // 4: byte saturation on the narrow instance, default window via cfg_window = 0
        s_trig_valid = 1; s_trig_ready = 1;
        s_ev_valid = 1; s_ev_ready = 1; s_ev_ok = 1; s_ev_len = 8'd248;
        @(negedge aclk);
        s_trig_valid = 0; s_trig_ready = 0;
        first = -1;
        for (int k = 1; k <= 24; k++) begin
            s_ev_valid = (k <= 2) ? 1'b1 : 1'b0;
            s_ev_len   = (k == 1) ? 8'd16 : 8'd10;
            @(negedge aclk);
            if (s_win_done && first < 0) first = k;
        end
        s_ev_valid = 0; s_ev_ready = 0; s_ev_ok = 0;
        chk("t4_default_window_done", 64'(first), 64'd19);
        srd("t4_sat_bytes", 8'd4, 64'd255);
        srd("t4_events", 8'd3, 64'd3);
        srd("t4_win_len", 8'd1, 64'd20);
        srd("t4_out_of_range", 8'd5, 64'd0);

        // 6: async reset between edges during RUN
        pulse_clear();
        cfg_window = 50;
        pulse_trig();
        @(negedge aclk);
        chk("t6_busy_before", 64'(busy), 64'd1);
        issue(8'd1, 64'd50);
        @(posedge aclk);
        #2;
        rd_en = 1'b0;
        aresetn = 1'b0;
        #1;
        chk("t6_async_busy", 64'(busy), 64'd0);
        chk("t6_async_rd_valid", 64'(rd_valid), 64'd0);
        chk("t6_async_rd_data", rd_data, 64'd0);
        chk("t6_async_win_done", 64'(win_done), 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        rd(8'd200, 64'd0);
        rd(8'd1, 64'd0);
        rd(8'd0, 64'd0);

        repeat (2) @(negedge aclk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
